msi_req_arbiter: RTL and testbench
==================================

Name: msi_req_arbiter

Overview:
- Shares the single MSI request/grant interface of the AXI-PCIe bridge between up to 4 MSI-producing requesters, such as several MSI IRQ collectors in different clock/feature groups.
- Captures one-cycle request pulses with their 5-bit vectors and serves pending requesters round-robin.
- Issues one MSI request at a time to the bridge and waits for its grant.
- Supervises the grant with a timeout/retry counter; returns per-requester grant or drop pulses.

Parameters:
- NumberOfRequesters_Gen, 4, number of active requester ports (1..4); unused port bits are ignored.
- GrantTimeout_Gen, 1024, clocks spent in WaitGrant before a re-issue (2..65535).
- MaxRetries_Gen, 3, re-issues allowed after the first issue before the request is dropped (0..15).

Ports:
- SysClk_ClkIn  in  1  system clock.
- SysRstN_RstIn  in  1  reset, asynchronous, active-high.
- MsiIrqEnable_EnIn  in  1  MSI enabled by the PCIe core; low = flush and hold idle.
- Req_ValIn  in  4  per-requester one-cycle request pulse.
- ReqVector_DatIn  in  20  per-requester vector; bits [5i+4:5i] belong to requester i and are sampled with the Req_ValIn pulse.
- Grant_ValOut  out  4  one-cycle pulse: requester i's MSI was granted.
- Drop_ValOut  out  4  one-cycle pulse: requester i's request was discarded (overrun or retries exhausted).
- MsiReq_ValOut  out  1  request to bridge, one-cycle pulse per issue.
- MsiVectorNum_DatOut  out  5  vector accompanying MsiReq_ValOut; held until the next issue.
- MsiGrant_ValIn  in  1  grant from bridge.
- Busy_ValOut  out  1  high whenever the FSM is not in Idle.
- TimeoutCount_DatOut  out  16  count of dropped-by-timeout requests; saturates at 16'hFFFF.

Behaviour:
- Reset: all outputs 0, FSM Idle, pending flags 0, stored vectors 0, RrPtr 0, timer 0, retry counter 0, TimeoutCount 0.
- Capture, when enabled:
  - A Req_ValIn[i] pulse with pending[i]=0 sets pending[i] and stores the vector.
  - A pulse with pending[i]=1 is ignored and produces Drop_ValOut[i] on the next cycle. This includes a pulse while requester i is in service.
  - Exception: in the cycle pending[i] is being cleared (grant or drop of i), a new pulse on i is accepted. pending[i] stays 1 with the new vector, and no overrun drop is signalled.
- FSM states: Idle, Issue, WaitGrant.
- Idle:
  - If any pending bit is set, select the first pending index at or after RrPtr, wrapping modulo NumberOfRequesters_Gen. Latch it as Sel, clear the retry counter, go to Issue.
- Issue (1 cycle):
  - MsiReq_ValOut=1 and MsiVectorNum_DatOut = stored vector[Sel], both registered.
  - Timer cleared; go to WaitGrant.
- WaitGrant:
  - MsiReq_ValOut=0; timer increments each cycle.
  - MsiGrant_ValIn=1: Grant_ValOut[Sel] pulses next cycle, pending[Sel] cleared, RrPtr = Sel+1 (wrap), go to Idle.
  - Timer reaches GrantTimeout_Gen-1 with no grant and retries < MaxRetries_Gen: retries+1, go to Issue (re-issue with the same vector).
  - Timer reaches GrantTimeout_Gen-1 with no grant and retries = MaxRetries_Gen: Drop_ValOut[Sel] pulses, pending[Sel] cleared, TimeoutCount+1 (saturating), RrPtr = Sel+1, go to Idle.
  - Grant and timeout in the same cycle: the grant wins.
- MsiGrant_ValIn outside WaitGrant is ignored, including during the Issue cycle.
- Latency: a Req pulse in cycle t with the FSM idle gives MsiReq_ValOut high in cycle t+2. A grant in cycle g gives Grant_ValOut in g+1, and the earliest next MsiReq_ValOut is g+3.
- Fairness: after serving i, requester i is lowest priority. With all ports continuously pending, service order is 0,1,2,3,0,...
- Enable low:
  - Synchronously forces Idle, clears pending, timer and retries.
  - MsiReq_ValOut=0; Req_ValIn is ignored.
  - No Grant/Drop pulses are generated for flushed requests.
  - TimeoutCount and RrPtr are kept.
- Reset mid-WaitGrant: everything returns to reset values asynchronously; no pulses are emitted.
- Ports with index >= NumberOfRequesters_Gen: inputs ignored, Grant/Drop outputs tied 0.

Test Plan:
- Single request: Req_ValIn=4'b0010, vector[9:5]=5'd7 at cycle 0, grant at cycle 5 -> MsiReq_ValOut high cycle 2 with MsiVectorNum=7; Grant_ValOut=4'b0010 cycle 6; Busy low cycle 6.
- Round-robin: pulses on all 4 ports in the same cycle (vectors 0,1,2,3), bridge grants 2 cycles after each request -> issue order 0,1,2,3; then a new pulse on ports 0 and 3 -> 0 served first (RrPtr wrapped to 0).
- Timeout/retry: GrantTimeout_Gen=8, MaxRetries_Gen=2, no grant -> 3 MsiReq pulses spaced 9 cycles apart, then Drop_ValOut[Sel] pulse and TimeoutCount=1.
- Grant on the timeout cycle: grant asserted exactly when timer = GrantTimeout_Gen-1 -> Grant pulse, no re-issue, TimeoutCount unchanged.
- Overrun: second pulse on port 1 while it waits for grant -> Drop_ValOut=4'b0010 next cycle, vector unchanged. A pulse in the grant-clear cycle -> re-pended with the new vector, no drop.
- Enable drop: MsiIrqEnable_EnIn low for 1 cycle during WaitGrant with 3 ports pending -> Idle, pending=0, no Grant/Drop pulses; a late MsiGrant_ValIn is ignored.

Source files
------------

// File: rtl/msi_req_arbiter.sv
// Round-robin arbiter sharing the bridge's single MSI request/grant port between up to
// four requesters, with grant timeout, bounded re-issue and drop reporting.
module msi_req_arbiter #(
  parameter int NumberOfRequesters_Gen = 4,
  parameter int GrantTimeout_Gen       = 1024,
  parameter int MaxRetries_Gen         = 3
) (
  input  logic        SysClk_ClkIn,
  input  logic        SysRstN_RstIn,
  input  logic        MsiIrqEnable_EnIn,
  input  logic [3:0]  Req_ValIn,
  input  logic [19:0] ReqVector_DatIn,
  output logic [3:0]  Grant_ValOut,
  output logic [3:0]  Drop_ValOut,
  output logic        MsiReq_ValOut,
  output logic [4:0]  MsiVectorNum_DatOut,
  input  logic        MsiGrant_ValIn,
  output logic        Busy_ValOut,
  output logic [15:0] TimeoutCount_DatOut
);

  localparam logic [3:0]  ActiveMask = 4'((32'd1 << NumberOfRequesters_Gen) - 32'd1);
  localparam logic [15:0] TimerLast  = 16'(GrantTimeout_Gen - 1);
  localparam logic [3:0]  RetryMax   = 4'(MaxRetries_Gen);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_GRANT} state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  state_t      state_q, state_d;
  logic [3:0]  pending_q;
  logic [4:0]  vec_q [4];
  logic [1:0]  rr_q, sel_q;
  logic [15:0] timer_q;
  logic [3:0]  retry_q;
  logic        done_q;
  logic [3:0]  grant_q, drop_q;
  logic        msi_req_q;
  logic [4:0]  msi_vec_q;
  logic [15:0] timeout_cnt_q;

  logic [3:0]  req_eff, sel_onehot, clear_vec, accept, overrun;
  logic        grant_now, timeout_now, retire_drop;
  logic [1:0]  issue_idx, rr_next;
  pick_t       pick;

  // First pending index at or after rr, wrapping modulo the active requester count.
  function automatic pick_t rr_pick(input logic [3:0] pend, input logic [1:0] rr);
    pick_t res;
    int    idx;
    res = '0;
    for (int off = 0; off < NumberOfRequesters_Gen; off++) begin
      idx = int'(rr) + off;
      if (idx >= NumberOfRequesters_Gen) idx -= NumberOfRequesters_Gen;
      if (!res.found && pend[idx[1:0]]) begin
        res.found = 1'b1;
        res.idx   = idx[1:0];
      end
    end
    return res;
  endfunction

  assign req_eff     = Req_ValIn & ActiveMask & {4{MsiIrqEnable_EnIn}};
  assign sel_onehot  = 4'b0001 << sel_q;
  assign grant_now   = MsiIrqEnable_EnIn && (state_q == WAIT_GRANT) && MsiGrant_ValIn;
  assign timeout_now = MsiIrqEnable_EnIn && (state_q == WAIT_GRANT) && !MsiGrant_ValIn &&
                       (timer_q == TimerLast);
  assign retire_drop = timeout_now && (retry_q == RetryMax);
  assign clear_vec   = (grant_now || retire_drop) ? sel_onehot : 4'b0000;
  // A pulse landing in the cycle its pending flag retires re-arms it instead of overrunning.
  assign accept      = req_eff & (~pending_q | clear_vec);
  assign overrun     = req_eff & pending_q & ~clear_vec;
  assign pick        = rr_pick(pending_q, rr_q);
  assign issue_idx   = (state_q == IDLE) ? pick.idx : sel_q;
  assign rr_next     = (int'(sel_q) == NumberOfRequesters_Gen - 1) ? 2'd0 : sel_q + 2'd1;

  // NOTE: every variable written in an always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // done_q holds off arbitration for the cycle a completion pulse is on the outputs.
      IDLE:       if (pick.found && !done_q) state_d = ISSUE;
      ISSUE:      state_d = WAIT_GRANT;
      WAIT_GRANT: begin
        if (grant_now || retire_drop) state_d = IDLE;
        else if (timeout_now)         state_d = ISSUE;
      end
      default:    state_d = IDLE;
    endcase
    if (!MsiIrqEnable_EnIn) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge SysClk_ClkIn or posedge SysRstN_RstIn) begin
    if (SysRstN_RstIn) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      // NOTE: the vector store is a tiny flop array and is reset like any other state,
      // so a freshly reset part never issues a stale vector.
      for (int i = 0; i < 4; i++) vec_q[i] <= '0;
      rr_q          <= '0;
      sel_q         <= '0;
      timer_q       <= '0;
      retry_q       <= '0;
      done_q        <= 1'b0;
      grant_q       <= '0;
      drop_q        <= '0;
      msi_req_q     <= 1'b0;
      msi_vec_q     <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= MsiIrqEnable_EnIn ? ((pending_q & ~clear_vec) | accept) : 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (accept[i]) vec_q[i] <= ReqVector_DatIn[5*i +: 5];
      end

      grant_q   <= grant_now ? (sel_onehot & ActiveMask) : 4'b0000;
      drop_q    <= (overrun | (retire_drop ? sel_onehot : 4'b0000)) & ActiveMask;
      done_q    <= grant_now || retire_drop;
      msi_req_q <= (state_d == ISSUE);
      if (state_d == ISSUE) msi_vec_q <= vec_q[issue_idx];

      if (grant_now || retire_drop) rr_q <= rr_next;
      if (retire_drop && timeout_cnt_q != 16'hFFFF) timeout_cnt_q <= timeout_cnt_q + 16'd1;

      if (!MsiIrqEnable_EnIn) begin
        timer_q <= '0;
        retry_q <= '0;
      end else begin
        if (state_q == IDLE && state_d == ISSUE) begin
          sel_q   <= pick.idx;
          retry_q <= '0;
        end else if (timeout_now && !retire_drop) begin
          retry_q <= retry_q + 4'd1;
        end
        if (state_q == WAIT_GRANT) timer_q <= timer_q + 16'd1;
        else                       timer_q <= '0;
      end
    end
  end

  assign Grant_ValOut        = grant_q;
  assign Drop_ValOut         = drop_q;
  assign MsiReq_ValOut       = msi_req_q;
  assign MsiVectorNum_DatOut = msi_vec_q;
  assign Busy_ValOut         = (state_q != IDLE);
  assign TimeoutCount_DatOut = timeout_cnt_q;

endmodule

// File: tb/tb_msi_req_arbiter.sv
// Directed bench for msi_req_arbiter: latency, round-robin, retry/timeout, overrun,
// enable flush, async reset and unused-port handling.
module tb_msi_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [19:0] vec;
  logic        gnt;

  logic [3:0]  grant_o, drop_o;
  logic        msireq_o, busy_o;
  logic [4:0]  msivec_o;
  logic [15:0] tocnt_o;

  logic [3:0]  grant3_o, drop3_o;
  logic        msireq3_o, busy3_o;
  logic [4:0]  msivec3_o;
  logic [15:0] tocnt3_o;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  msi_req_arbiter #(.NumberOfRequesters_Gen(4), .GrantTimeout_Gen(8), .MaxRetries_Gen(2)) u_dut (
    .SysClk_ClkIn(clk), .SysRstN_RstIn(rst), .MsiIrqEnable_EnIn(en),
    .Req_ValIn(req), .ReqVector_DatIn(vec),
    .Grant_ValOut(grant_o), .Drop_ValOut(drop_o),
    .MsiReq_ValOut(msireq_o), .MsiVectorNum_DatOut(msivec_o),
    .MsiGrant_ValIn(gnt), .Busy_ValOut(busy_o), .TimeoutCount_DatOut(tocnt_o)
  );

  msi_req_arbiter #(.NumberOfRequesters_Gen(3), .GrantTimeout_Gen(8), .MaxRetries_Gen(2)) u_dut3 (
    .SysClk_ClkIn(clk), .SysRstN_RstIn(rst), .MsiIrqEnable_EnIn(en),
    .Req_ValIn(req), .ReqVector_DatIn(vec),
    .Grant_ValOut(grant3_o), .Drop_ValOut(drop3_o),
    .MsiReq_ValOut(msireq3_o), .MsiVectorNum_DatOut(msivec3_o),
    .MsiGrant_ValIn(gnt), .Busy_ValOut(busy3_o), .TimeoutCount_DatOut(tocnt3_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; req = '0; vec = '0; gnt = 1'b0;
    repeat (3) tick();
    check("rst_grant", grant_o, 4'h0);
    check("rst_drop", drop_o, 4'h0);
    check("rst_msireq", msireq_o, 1'b0);
    check("rst_vec", msivec_o, 5'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_tocnt", tocnt_o, 16'd0);
    rst = 1'b0;
    tick();

    // Single request on port 1, grant in cycle 5.
    req = 4'b0010; vec = 20'd7 << 5;
    tick(); req = '0;
    check("single_no_early_req", msireq_o, 1'b0);
    tick();
    check("single_req_c2", msireq_o, 1'b1);
    check("single_vec_c2", msivec_o, 5'd7);
    check("single_busy_c2", busy_o, 1'b1);
    tick();
    check("single_req_pulse", msireq_o, 1'b0);
    check("single_vec_held", msivec_o, 5'd7);
    tick(); tick();
    gnt = 1'b1;
    tick(); gnt = 1'b0;
    check("single_grant_c6", grant_o, 4'b0010);
    check("single_busy_c6", busy_o, 1'b0);
    tick();
    check("single_grant_pulse", grant_o, 4'b0000);

    // Round-robin: all four ports at once, grant two cycles after each issue.
    do_reset();
    req = 4'b1111; vec = {5'd3, 5'd2, 5'd1, 5'd0};
    tick(); req = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_req_%0d", k), msireq_o, 1'b1);
      check($sformatf("rr_vec_%0d", k), msivec_o, 32'(k));
      tick(); tick();
      gnt = 1'b1;
      tick(); gnt = 1'b0;
      check($sformatf("rr_grant_%0d", k), grant_o, 32'(4'b0001 << k));
      tick(); tick();
    end
    req = 4'b1001; vec = {5'd13, 5'd0, 5'd0, 5'd10};
    tick(); req = '0;
    tick();
    check("rr_wrap_vec", msivec_o, 5'd10);
    tick(); tick();
    gnt = 1'b1;
    tick(); gnt = 1'b0;
    check("rr_wrap_grant0", grant_o, 4'b0001);
    tick();
    check("rr_wrap_gap", msireq_o, 1'b0);
    tick();
    check("rr_wrap_vec3", msivec_o, 5'd13);
    tick(); tick();
    gnt = 1'b1;
    tick(); gnt = 1'b0;
    check("rr_wrap_grant3", grant_o, 4'b1000);
    tick();

    // Overrun on port 1 before and during service, then re-pend in the grant-clear cycle.
    req = 4'b0010; vec = 20'd5 << 5;
    tick(); vec = 20'd9 << 5;
    tick(); req = '0;
    check("ovr_drop_pending", drop_o, 4'b0010);
    check("ovr_vec_unchanged", msivec_o, 5'd5);
    tick(); req = 4'b0010;
    tick(); req = '0;
    check("ovr_drop_service", drop_o, 4'b0010);
    tick();
    check("ovr_drop_pulse", drop_o, 4'b0000);
    gnt = 1'b1; req = 4'b0010; vec = 20'd11 << 5;
    tick(); gnt = 1'b0; req = '0;
    check("repend_grant", grant_o, 4'b0010);
    check("repend_no_drop", drop_o, 4'b0000);
    tick(); tick();
    check("repend_req", msireq_o, 1'b1);
    check("repend_vec", msivec_o, 5'd11);
    tick(); tick();
    gnt = 1'b1;
    tick(); gnt = 1'b0;
    check("repend_grant2", grant_o, 4'b0010);
    tick();

    // Timeout/retry on port 2: issues at 2, 11, 20; drop at 29.
    req = 4'b0100; vec = 20'd17 << 10;
    tick(); req = '0;
    tick();
    check("to_req1", msireq_o, 1'b1);
    repeat (8) tick();
    check("to_gap", msireq_o, 1'b0);
    tick();
    check("to_req2", msireq_o, 1'b1);
    check("to_vec2", msivec_o, 5'd17);
    repeat (9) tick();
    check("to_req3", msireq_o, 1'b1);
    repeat (8) tick();
    check("to_no_drop_yet", drop_o, 4'b0000);
    check("to_busy_c28", busy_o, 1'b1);
    tick();
    check("to_drop", drop_o, 4'b0100);
    check("to_count", tocnt_o, 16'd1);
    check("to_idle", busy_o, 1'b0);
    tick();
    check("to_drop_pulse", drop_o, 4'b0000);

    // Grant coinciding with the timeout cycle on port 3.
    req = 4'b1000; vec = 20'd21 << 15;
    tick(); req = '0;
    tick();
    check("gto_vec", msivec_o, 5'd21);
    repeat (8) tick();
    gnt = 1'b1;
    tick(); gnt = 1'b0;
    check("gto_grant", grant_o, 4'b1000);
    check("gto_no_reissue", msireq_o, 1'b0);
    check("gto_no_drop", drop_o, 4'b0000);
    check("gto_count", tocnt_o, 16'd1);
    tick();
    check("gto_idle", busy_o, 1'b0);
    tick();

    // Enable low for one cycle during WaitGrant with three ports pending.
    req = 4'b0111; vec = {5'd0, 5'd3, 5'd2, 5'd1};
    tick(); req = '0;
    tick();
    check("en_vec", msivec_o, 5'd1);
    tick();
    en = 1'b0; req = 4'b1000;
    tick(); en = 1'b1; req = '0; gnt = 1'b1;
    check("en_busy", busy_o, 1'b0);
    check("en_grant", grant_o, 4'b0000);
    check("en_drop", drop_o, 4'b0000);
    tick(); gnt = 1'b0;
    check("en_late_grant", grant_o, 4'b0000);
    check("en_no_reissue", msireq_o, 1'b0);
    tick();
    check("en_flushed_req", msireq_o, 1'b0);
    check("en_flushed_busy", busy_o, 1'b0);
    check("en_flushed_drop", drop_o, 4'b0000);
    check("en_tocnt_kept", tocnt_o, 16'd1);

    // Asynchronous reset in WaitGrant.
    req = 4'b0010; vec = 20'd4 << 5;
    tick(); req = '0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("arst_busy", busy_o, 1'b0);
    check("arst_tocnt", tocnt_o, 16'd0);
    check("arst_vec", msivec_o, 5'd0);
    tick(); rst = 1'b0;
    tick();
    check("arst_grant", grant_o, 4'b0000);
    check("arst_drop", drop_o, 4'b0000);
    check("arst_req", msireq_o, 1'b0);

    // Port 3 is ignored by the three-port instance.
    req = 4'b1000; vec = 20'd6 << 15;
    tick(); vec = 20'd8 << 15;
    tick(); req = '0;
    check("unused_main_drop", drop_o, 4'b1000);
    check("unused_main_vec", msivec_o, 5'd6);
    check("unused_drop", drop3_o, 4'b0000);
    check("unused_busy", busy3_o, 1'b0);
    check("unused_req", msireq3_o, 1'b0);
    check("unused_vec", msivec3_o, 5'd0);
    check("unused_tocnt", tocnt3_o, 16'd0);
    tick(); gnt = 1'b1;
    tick(); gnt = 1'b0;
    check("unused_main_grant", grant_o, 4'b1000);
    check("unused_grant", grant3_o, 4'b0000);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
